// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Multiply uses shift-add on a 64-bit accumulator. Divide uses restoring division.
// Both retire one bit per cycle. The pipeline stalls while busy_o is high.
module riscv_muldiv (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's complement negation helpers
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    state_t      state_r;
    logic [2:0]  op_r;
    logic [63:0] acc_r;       // mul: {product_hi, multiplier}; div: {remainder, quotient}
    logic [31:0] opb_r;       // mul: |multiplicand|; div: |divisor|
    logic [4:0]  cnt_r;
    logic        neg_res_r;   // product / quotient must be negated
    logic        neg_rem_r;   // remainder must be negated
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;

    logic        a_signed_s;
    logic        b_signed_s;
    logic        sa_s;
    logic        sb_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic        div_zero_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] div_top_s;
    logic [31:0] div_diff_s;
    logic [63:0] div_next_s;
    logic [63:0] iter_next_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] fix_result_s;

    // Decode operand signedness and form magnitudes of the incoming operands
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'b010: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        sa_s = a_signed_s & a_i[31];
        sb_s = b_signed_s & b_i[31];
        if (sa_s) begin
            a_mag_s = neg32(a_i);
        end else begin
            a_mag_s = a_i;
        end
        if (sb_s) begin
            b_mag_s = neg32(b_i);
        end else begin
            b_mag_s = b_i;
        end
        div_zero_s = op_i[2] & (b_i == 32'd0);
    end

    // One radix-2 step of the multiply or divide datapath
    always_comb begin
        mul_sum_s = {1'b0, acc_r[63:32]} + {1'b0, opb_r};
        if (acc_r[0]) begin
            mul_next_s = {mul_sum_s, acc_r[31:1]};
        end else begin
            mul_next_s = {1'b0, acc_r[63:32], acc_r[31:1]};
        end
        // Shifted remainder needs 33 bits; it fits back in 32 after the trial subtract
        div_top_s  = acc_r[63:31];
        div_diff_s = div_top_s[31:0] - opb_r;
        if (div_top_s >= {1'b0, opb_r}) begin
            div_next_s = {div_diff_s, acc_r[30:0], 1'b1};
        end else begin
            div_next_s = {div_top_s[31:0], acc_r[30:0], 1'b0};
        end
        if (op_r[2]) begin
            iter_next_s = div_next_s;
        end else begin
            iter_next_s = mul_next_s;
        end
    end

    // Sign fix-up and result selection
    always_comb begin
        if (neg_res_r) begin
            prod_s = neg64(acc_r);
            quot_s = neg32(acc_r[31:0]);
        end else begin
            prod_s = acc_r;
            quot_s = acc_r[31:0];
        end
        if (neg_rem_r) begin
            rem_s = neg32(acc_r[63:32]);
        end else begin
            rem_s = acc_r[63:32];
        end
        case (op_r)
            3'b000:                 fix_result_s = prod_s[31:0];
            3'b001, 3'b010, 3'b011: fix_result_s = prod_s[63:32];
            3'b100, 3'b101:         fix_result_s = quot_s;
            3'b110, 3'b111:         fix_result_s = rem_s;
            default:                fix_result_s = 32'd0;
        endcase
    end

    // Control FSM, working registers and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            op_r      <= 3'd0;
            acc_r     <= 64'd0;
            opb_r     <= 32'd0;
            cnt_r     <= 5'd0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    if (kill_i) begin
                        state_r <= ST_IDLE;
                    end else if (valid_i) begin
                        op_r <= op_i;
                        if (div_zero_s) begin
                            // REM/REMU return the dividend, DIV/DIVU return all ones
                            result_r <= op_i[1] ? a_i : 32'hFFFF_FFFF;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            opb_r     <= op_i[2] ? b_mag_s : a_mag_s;
                            acc_r     <= {32'd0, (op_i[2] ? a_mag_s : b_mag_s)};
                            neg_res_r <= sa_s ^ sb_s;
                            neg_rem_r <= sa_s;
                            cnt_r     <= 5'd31;
                            busy_r    <= 1'b1;
                            state_r   <= ST_ITER;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ITER: begin
                    if (kill_i) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        acc_r <= iter_next_s;
                        if (cnt_r == 5'd0) begin
                            state_r <= ST_FIX;
                        end else begin
                            cnt_r <= cnt_r - 5'd1;
                        end
                    end
                end
                ST_FIX: begin
                    busy_r <= 1'b0;
                    if (kill_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        result_r <= fix_result_s;
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign result_o = result_r;

endmodule
